// File: rtl/dbus_access_unit_if.sv
// Data-bus request/response bundle between the memory-stage access unit and the bus.
// The access unit drives dreq through the master modport; the bus answers on dresp.
interface dbus_access_unit_if #(parameter int XLEN = 64);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        logic [2:0]        size;   // MSIZE1=0, MSIZE2=1, MSIZE4=2, MSIZE8=3
        logic [XLEN/8-1:0] strobe;
        logic [XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_access_unit.sv
// Memory-stage data-bus engine: one load/store at a time over a BUSY-until-data_ok handshake,
// with store lane placement, load extension, stall generation and a one-cycle completion pulse.
module dbus_access_unit #(
    parameter int XLEN        = 64,
    parameter int CHECK_ALIGN = 1,
    parameter int MMIO_BIT    = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic             flush,
    dbus_access_unit_if.master bus,
    output logic             stall,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_misalign,
    output logic             resp_mmio
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              kill;
    logic [XLEN-1:0]   lat_addr;
    logic [1:0]        lat_size;
    logic              lat_write;
    logic              lat_unsigned;
    logic [XLEN/8-1:0] lat_strobe;
    logic [XLEN-1:0]   lat_data;

    logic              aligned;
    logic [XLEN/8-1:0] size_mask;
    logic [XLEN/8-1:0] strobe_next;
    logic [XLEN-1:0]   data_next;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_ext;
    logic              sgn;
    logic              unused_addr_ok;

    assign unused_addr_ok = bus.dresp.addr_ok;

    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (req_size)
            2'd0: begin aligned = 1'b1;                  size_mask = 8'h01; end
            2'd1: begin aligned = ~req_addr[0];          size_mask = 8'h03; end
            2'd2: begin aligned = (req_addr[1:0] == 2'b0); size_mask = 8'h0F; end
            default: begin aligned = (req_addr[2:0] == 3'b0); size_mask = 8'hFF; end
        endcase
    end

    // Lanes beyond the 64-bit word simply fall off the top of the shift.
    assign strobe_next = size_mask << req_addr[2:0];
    assign data_next   = req_wdata << {req_addr[2:0], 3'b000};

    assign shifted = bus.dresp.data >> {lat_addr[2:0], 3'b000};
    assign sgn     = ~lat_unsigned;

    always_comb begin
        load_ext = shifted;
        case (lat_size)
            2'd0:    load_ext = {{(XLEN-8){sgn & shifted[7]}},   shifted[7:0]};
            2'd1:    load_ext = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
            2'd2:    load_ext = {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            kill          <= 1'b0;
            lat_addr      <= '0;
            lat_size      <= '0;
            lat_write     <= 1'b0;
            lat_unsigned  <= 1'b0;
            lat_strobe    <= '0;
            lat_data      <= '0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            resp_mmio     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (req_valid && !flush) begin
                        lat_addr     <= req_addr;
                        lat_size     <= req_size;
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        lat_strobe   <= req_write ? strobe_next : '0;
                        lat_data     <= req_write ? data_next : '0;
                        if (aligned || CHECK_ALIGN == 0) begin
                            state <= BUSY;
                        end else begin
                            // Misaligned: skip the bus and report straight from DONE.
                            state         <= DONE;
                            resp_rdata    <= '0;
                            resp_misalign <= 1'b1;
                            resp_mmio     <= ~req_addr[MMIO_BIT];
                        end
                    end
                end
                BUSY: begin
                    if (flush) kill <= 1'b1;
                    if (bus.dresp.data_ok) begin
                        state         <= DONE;
                        resp_rdata    <= lat_write ? '0 : load_ext;
                        resp_misalign <= 1'b0;
                        resp_mmio     <= ~lat_addr[MMIO_BIT];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dreq.valid  = (state == BUSY);
    assign bus.dreq.addr   = lat_addr;
    assign bus.dreq.size   = {1'b0, lat_size};
    assign bus.dreq.strobe = lat_strobe;
    assign bus.dreq.data   = lat_data;

    assign stall      = req_valid & (((state == IDLE) & ~flush) | (state == BUSY));
    assign resp_valid = (state == DONE) & ~kill & ~flush;
endmodule
